// File: rtl/instr_fetch.sv
// instr_fetch: program-fetch stage for the 8-bit LED CPU.
// Drives a 1-cycle-latency single-port program RAM, holds returned words in a
// 2-entry FIFO and hands them to the decoder over valid/ready.
// Optional build macro FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module instr_fetch #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_ad,
  output logic              mem_ce,
  output logic              mem_oce,
  output logic              mem_wre,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] ent0_instr_q, ent0_instr_d, ent1_instr_q, ent1_instr_d;
  logic [ADDR_W-1:0] ent0_pc_q, ent0_pc_d, ent1_pc_q, ent1_pc_d;

  logic              pop;
  logic [2:0]        occ;
  logic              room;
  logic              issue;
  logic [1:0]        base;

  // Handshake and issue qualification; the in-flight read reserves a slot.
  assign pop   = instr_valid & instr_ready;
  assign occ   = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign room  = (occ < 3'd2);
  assign issue = (state_q == ST_RUN) & ~halt & ~jump_en & room;
  assign base  = cnt_q - 2'(pop);

  assign mem_ce      = issue;
  assign mem_ad      = pc_q;
  assign mem_oce     = 1'b1;
  assign mem_wre     = 1'b0;
  assign instr_valid = (cnt_q != 2'd0);
  assign instr       = ent0_instr_q;
  assign instr_pc    = ent0_pc_q;

  // Next-state: FSM, pc/issue tracking, FIFO shift-on-pop with tail write.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    cnt_d         = cnt_q;
    ent0_instr_d  = ent0_instr_q;
    ent0_pc_d     = ent0_pc_q;
    ent1_instr_d  = ent1_instr_q;
    ent1_pc_d     = ent1_pc_q;

    case (state_q)
      ST_START:  state_d = ST_RUN;
      ST_RUN:    if (halt) state_d = ST_HALTED;
      ST_HALTED: if (!halt) state_d = ST_RUN;
      default:   state_d = ST_START;
    endcase

    if (jump_en) begin
      // Redirect wins: flush buffer and drop any read still in flight.
      pc_d  = jump_addr;
      cnt_d = 2'd0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + ADDR_W'(1);
      end
      if (pop) begin
        ent0_instr_d = ent1_instr_q;
        ent0_pc_d    = ent1_pc_q;
      end
      if (inflight_q) begin
        if (base == 2'd0) begin
          ent0_instr_d = mem_dout;
          ent0_pc_d    = inflight_pc_q;
        end else begin
          ent1_instr_d = mem_dout;
          ent1_pc_d    = inflight_pc_q;
        end
      end
      cnt_d = base + 2'(inflight_q);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_START;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      cnt_q         <= 2'd0;
      ent0_instr_q  <= '0;
      ent0_pc_q     <= '0;
      ent1_instr_q  <= '0;
      ent1_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      cnt_q         <= cnt_d;
      ent0_instr_q  <= ent0_instr_d;
      ent0_pc_q     <= ent0_pc_d;
      ent1_instr_q  <= ent1_instr_d;
      ent1_pc_q     <= ent1_pc_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where the decoder holds off a valid word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (instr_valid && !instr_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a 1-cycle RAM model.
// Build with FETCH_STALL_CNT_EN to also exercise the stall counter.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] mem_ad;
  logic        mem_ce, mem_oce, mem_wre;
  logic [15:0] mem_dout = 16'h0000;
  logic        jump_en;
  logic [10:0] jump_addr;
  logic        halt;
  logic [15:0] instr;
  logic [10:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [15:0] ram [2048];
  logic [10:0] sb_q [$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_ad      (mem_ad),
    .mem_ce      (mem_ce),
    .mem_oce     (mem_oce),
    .mem_wre     (mem_wre),
    .mem_dout    (mem_dout),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Program RAM model: registered read, one cycle latency.
  always @(posedge clk) begin
    if (mem_ce) mem_dout <= ram[mem_ad];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [10:0] first, input int n);
    logic [10:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(a);
      a = a + 11'd1;
    end
  endtask

  // Scoreboard: every accepted instruction must match the next expected pc.
  always @(negedge clk) begin
    logic [10:0] exp_pc;
    if (rst_n && instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underrun", 32'(instr_pc), 32'hFFFF_FFFF);
      end else begin
        exp_pc = sb_q.pop_front();
        check("sb_pc", 32'(instr_pc), 32'(exp_pc));
        check("sb_instr", 32'(instr), 32'(ram[exp_pc]));
        check("sb_wre", 32'(mem_wre), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) ram[i] = 16'((i * 40503) ^ 16'h1234);
    ram[0] = 16'h00A1; ram[1] = 16'h0078; ram[2] = 16'h0066; ram[3] = 16'h0091;

    rst_n = 1'b0; instr_ready = 1'b0; halt = 1'b0; jump_en = 1'b0; jump_addr = '0;
    repeat (3) tick();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_ce", 32'(mem_ce), 32'd0);
    check("rst_ad", 32'(mem_ad), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    check("rst_oce", 32'(mem_oce), 32'd1);
    check("rst_wre", 32'(mem_wre), 32'd0);

    // Startup latency and full-rate streaming, then halt.
    push_range(11'd0, 5);
    instr_ready = 1'b1; rst_n = 1'b1;
    tick();
    check("first_issue_ce", 32'(mem_ce), 32'd1);
    n = 1;
    while (!instr_valid && n < 10) begin
      tick();
      n++;
    end
    check("first_valid_lat", 32'(n), 32'd3);
    check("first_pc", 32'(instr_pc), 32'd0);
    repeat (3) tick();
    halt = 1'b1;
    #1 check("halt_ce", 32'(mem_ce), 32'd0);
    repeat (4) tick();
    check("halt_ce_hold", 32'(mem_ce), 32'd0);
    check("halt_drained", 32'(instr_valid), 32'd0);
    check("halt_sb_empty", 32'(sb_q.size()), 32'd0);
    check("halt_next_pc", 32'(mem_ad), 32'd5);

    // Resume, then backpressure for five cycles.
    halt = 1'b0;
    push_range(11'd5, 20);
    tick();
    check("resume_ce", 32'(mem_ce), 32'd1);
    check("resume_ad", 32'(mem_ad), 32'd5);
    tick();
    tick();
    instr_ready = 1'b0;
    #1 check("bp_ce", 32'(mem_ce), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_pc", 32'(instr_pc), 32'd5);
      check("bp_instr", 32'(instr), 32'(ram[5]));
      check("bp_ce_hold", 32'(mem_ce), 32'd0);
    end
    instr_ready = 1'b1;
    repeat (6) tick();

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_ce", 32'(mem_ce), 32'd0);
    check("arst_pc", 32'(instr_pc), 32'd0);
    check("arst_ad", 32'(mem_ad), 32'd0);
    sb_q.delete();

    // Restart stalled, then jump while pc1 is buffered and pc2 in flight.
    instr_ready = 1'b0;
    tick();
    tick();
`ifdef FETCH_STALL_CNT_EN
    check("stall_rst", 32'(stall_cnt), 32'd0);
`endif
    push_range(11'd0, 1);
    rst_n = 1'b1;
    repeat (6) tick();
    check("stall_pc", 32'(instr_pc), 32'd0);
    check("stall_ce", 32'(mem_ce), 32'd0);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt3", 32'(stall_cnt), 32'd3);
`endif
    instr_ready = 1'b1;
    #1;
    check("pj_ce", 32'(mem_ce), 32'd1);
    check("pj_ad", 32'(mem_ad), 32'd2);
    tick();
    instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 11'h005;
    #1;
    check("jump_ce", 32'(mem_ce), 32'd0);
    check("jump_head", 32'(instr_pc), 32'd1);
    @(negedge clk);
    #1;
    check("pj_sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    push_range(11'h005, 16);
    tick();
    jump_en = 1'b0; instr_ready = 1'b1;
    #1;
    check("j1_valid", 32'(instr_valid), 32'd0);
    check("j1_ad", 32'(mem_ad), 32'h005);
    tick();
    check("j2_valid", 32'(instr_valid), 32'd0);
    tick();
    check("j3_valid", 32'(instr_valid), 32'd1);
    check("j3_pc", 32'(instr_pc), 32'h005);
    repeat (3) tick();

    // Jump near the top of the address space to exercise pc wrap.
    jump_en = 1'b1; jump_addr = 11'h7FE;
    @(negedge clk);
    #1;
    sb_q.delete();
    push_range(11'h7FE, 6);
    tick();
    jump_en = 1'b0;
    repeat (8) tick();
    check("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
